// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (LSB first, idle-high line) with a one-byte ready/read
// handshake and sticky overrun / framing-error flags. Define UART_RX_SYNC_EN for an async rx.
module uart_rx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_ready,
   input  logic       data_read,
   output logic       overrun,
   output logic       framing_err
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int TICK_W       = $clog2(CLKS_PER_BIT + 1);

   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(HALF_BIT);
   localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(CLKS_PER_BIT);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_baud
         $error("uart_rx: CLK_FREQ / BAUD_RATE must be at least 2");
      end
   endgenerate

   logic rx_s;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], rx};
      end
   end

   assign rx_s = sync_reg[1];
`else
   assign rx_s = rx;
`endif

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t            state_reg,   state_next;
   logic [TICK_W-1:0] tick_reg,    tick_next;
   logic [2:0]        bit_reg,     bit_next;
   logic [7:0]        shift_reg,   shift_next;
   logic              commit_reg,  commit_next;
   logic              ferr_evt_reg, ferr_evt_next;
   logic [7:0]        data_reg,    data_next;
   logic              ready_reg,   ready_next;
   logic              overrun_reg, overrun_next;
   logic              ferr_reg,    ferr_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= WAIT_IDLE;
         tick_reg     <= '0;
         bit_reg      <= '0;
         shift_reg    <= '0;
         commit_reg   <= 1'b0;
         ferr_evt_reg <= 1'b0;
         data_reg     <= '0;
         ready_reg    <= 1'b0;
         overrun_reg  <= 1'b0;
         ferr_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         tick_reg     <= tick_next;
         bit_reg      <= bit_next;
         shift_reg    <= shift_next;
         commit_reg   <= commit_next;
         ferr_evt_reg <= ferr_evt_next;
         data_reg     <= data_next;
         ready_reg    <= ready_next;
         overrun_reg  <= overrun_next;
         ferr_reg     <= ferr_next;
      end
   end

   // Frame sequencing: tick counts clocks since the last sample point.
   always_comb begin
      state_next    = state_reg;
      tick_next     = tick_reg;
      bit_next      = bit_reg;
      shift_next    = shift_reg;
      commit_next   = 1'b0;
      ferr_evt_next = 1'b0;

      case (state_reg)
         WAIT_IDLE: begin
            if (rx_s) begin
               state_next = IDLE;
            end
         end
         IDLE: begin
            if (!rx_s) begin
               tick_next  = TICK_ONE;
               state_next = START;
            end
         end
         START: begin
            if (tick_reg == TICK_HALF) begin
               if (!rx_s) begin
                  state_next = DATA;
                  tick_next  = TICK_ONE;
                  bit_next   = 3'd0;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               tick_next = tick_reg + TICK_ONE;
            end
         end
         DATA: begin
            if (tick_reg == TICK_FULL) begin
               shift_next[bit_reg] = rx_s;
               tick_next           = TICK_ONE;
               bit_next            = bit_reg + 3'd1;
               if (bit_reg == 3'd7) begin
                  state_next = STOP;
               end
            end else begin
               tick_next = tick_reg + TICK_ONE;
            end
         end
         STOP: begin
            if (tick_reg == TICK_FULL) begin
               if (rx_s) begin
                  commit_next = 1'b1;
                  state_next  = IDLE;
               end else begin
                  ferr_evt_next = 1'b1;
                  state_next    = WAIT_IDLE;
               end
            end else begin
               tick_next = tick_reg + TICK_ONE;
            end
         end
         default: begin
            state_next = WAIT_IDLE;
         end
      endcase
   end

   // Host-side holding register; a new byte always wins over an unread one.
   always_comb begin
      data_next    = data_reg;
      ready_next   = ready_reg;
      overrun_next = overrun_reg;
      ferr_next    = ferr_reg;

      if (commit_reg) begin
         data_next    = shift_reg;
         ready_next   = 1'b1;
         overrun_next = data_read ? 1'b0 : (overrun_reg | ready_reg);
      end else if (data_read) begin
         ready_next   = 1'b0;
         overrun_next = 1'b0;
      end

      if (ferr_evt_reg) begin
         ferr_next = 1'b1;
      end else if (data_read) begin
         ferr_next = 1'b0;
      end
   end

   assign data        = data_reg;
   assign data_ready  = ready_reg;
   assign overrun     = overrun_reg;
   assign framing_err = ferr_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, hand-built corner sequences and a
// randomized frame stream checked against a frame-level reference model.
module tb_uart_rx;

   localparam int CLK_FREQ  = 50_000_000;
   localparam int BAUD_RATE = 25_000_000;
   localparam int N         = CLK_FREQ / BAUD_RATE;
   localparam int H         = N / 2;
`ifdef UART_RX_SYNC_EN
   localparam int SYNC_DLY  = 2;
`else
   localparam int SYNC_DLY  = 0;
`endif
   // Edge at which a frame's result becomes visible, relative to its start-bit edge.
   localparam int LAT       = H + 9 * N + 1 + SYNC_DLY;
   // With the synchronizer, its reset value of 1 releases WAIT_IDLE at once, so skip the low hold.
   localparam int HOLD_LOW  = (SYNC_DLY != 0) ? 0 : 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       data_ready;
   logic       data_read;
   logic       overrun;
   logic       framing_err;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   always #5 clk = ~clk;

   uart_rx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD_RATE(BAUD_RATE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .data       (data),
      .data_ready (data_ready),
      .data_read  (data_read),
      .overrun    (overrun),
      .framing_err(framing_err)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick(input logic rxv, input logic rdv, input logic rstv);
      @(negedge clk);
      rx        = rxv;
      data_read = rdv;
      rst       = rstv;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         if (miscompares <= 40)
            $display("FAIL %s at cycle %0d: got %02h, expected %02h", name, cyc, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [7:0] ed, input logic er,
                            input logic eo, input logic ef);
      check({name, ".data"}, data, ed);
      check({name, ".data_ready"}, {7'd0, data_ready}, {7'd0, er});
      check({name, ".overrun"}, {7'd0, overrun}, {7'd0, eo});
      check({name, ".framing_err"}, {7'd0, framing_err}, {7'd0, ef});
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input logic good, input int j);
      int slot;
      slot = j / N;
      if (slot == 0) return 1'b0;
      if (slot == 9) return good;
      return b[slot-1];
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic good, output int t0);
      t0 = cyc + 1;
      for (int j = 0; j < 10 * N; j++) tick(frame_bit(b, good, j), 1'b0, 1'b0);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick(1'b1, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      repeat (3) tick(1'b1, 1'b0, 1'b0);
   endtask

   // ---------------- scheduled line + frame-level model ----------------
   logic       q_rx[$];
   logic       q_rd[$];
   int         fr_pos[$];
   logic [7:0] fr_byte[$];
   logic       fr_good[$];

   function automatic void clear_q();
      q_rx.delete(); q_rd.delete();
      fr_pos.delete(); fr_byte.delete(); fr_good.delete();
   endfunction

   function automatic void add_idle(input int k);
      for (int i = 0; i < k; i++) begin
         q_rx.push_back(1'b1);
         q_rd.push_back(1'b0);
      end
   endfunction

   function automatic void add_glitch();
      q_rx.push_back(1'b0);
      q_rd.push_back(1'b0);
   endfunction

   function automatic void add_frame(input logic [7:0] b, input logic good);
      fr_pos.push_back(q_rx.size());
      fr_byte.push_back(b);
      fr_good.push_back(good);
      for (int j = 0; j < 10 * N; j++) begin
         q_rx.push_back(frame_bit(b, good, j));
         q_rd.push_back(1'b0);
      end
   endfunction

   task automatic play(input string name);
      logic [7:0] m_data = 8'h00;
      logic       m_rdy  = 1'b0;
      logic       m_ovr  = 1'b0;
      logic       m_fe   = 1'b0;
      logic       hit, good, rd;
      logic [7:0] b;
      for (int i = 0; i < q_rx.size(); i++) begin
         rd = q_rd[i];
         tick(q_rx[i], rd, 1'b0);
         hit = 1'b0; good = 1'b0; b = 8'h00;
         for (int k = 0; k < fr_pos.size(); k++) begin
            if (fr_pos[k] + LAT == i) begin
               hit = 1'b1; good = fr_good[k]; b = fr_byte[k];
            end
         end
         if (hit && good) begin
            m_ovr  = rd ? 1'b0 : (m_ovr | m_rdy);
            m_rdy  = 1'b1;
            m_data = b;
         end else if (rd) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
         end
         if (hit && !good) m_fe = 1'b1;
         else if (rd)      m_fe = 1'b0;
         check_all(name, m_data, m_rdy, m_ovr, m_fe);
      end
   endtask

   // ---------------- table-driven frames ----------------
   typedef struct {
      logic [7:0] din;
      logic       stop_ok;
      logic       read_after;
      logic [7:0] exp_data;
      logic       exp_rdy;
      logic       exp_ovr;
      logic       exp_fe;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int   t0;
      logic prev_rdy;
      logic prev_bad;

      rst = 1'b1; rx = 1'b1; data_read = 1'b0;

      tbl[0] = '{8'h45, 1'b1, 1'b1, 8'h45, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{8'h0A, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{8'h33, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{8'h44, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1};

      do_reset();
      prev_rdy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         send_frame(tbl[i].din, tbl[i].stop_ok, t0);
         wait_until(t0 + LAT - 1);
         check("table.ready_before_commit", {7'd0, data_ready}, {7'd0, prev_rdy});
         tick(1'b1, 1'b0, 1'b0);
         check_all("table", tbl[i].exp_data, tbl[i].exp_rdy, tbl[i].exp_ovr, tbl[i].exp_fe);
         prev_rdy = tbl[i].exp_rdy;
         if (tbl[i].read_after) begin
            tick(1'b1, 1'b1, 1'b0);
            check_all("table.after_read", tbl[i].exp_data, 1'b0, 1'b0, 1'b0);
            prev_rdy = 1'b0;
         end
      end

      // Back-to-back frames, simultaneous commit/read and framing/read, a glitch, then 0x55.
      do_reset();
      clear_q();
      add_idle(2);
      add_frame(8'h45, 1'b1);
      add_frame(8'h0A, 1'b1);
      add_frame(8'h11, 1'b1);
      add_frame(8'h22, 1'b1);
      add_frame(8'h33, 1'b0);
      add_idle(1);
      add_glitch();
      add_idle(N + 1);
      add_frame(8'h55, 1'b1);
      add_idle(LAT + 2);
      q_rd[fr_pos[0] + LAT + 1] = 1'b1;
      q_rd[fr_pos[1] + LAT + 1] = 1'b1;
      q_rd[fr_pos[3] + LAT]     = 1'b1;
      q_rd[fr_pos[4] + LAT]     = 1'b1;
      play("corner");

      // Randomized frame stream with random reads.
      do_reset();
      clear_q();
      add_idle(2);
      prev_bad = 1'b0;
      for (int f = 0; f < 40; f++) begin
         int   gap;
         logic good;
         gap = int'($urandom_range(0, 3));
         if (prev_bad && gap == 0) gap = 1;
         add_idle(gap);
         if ($urandom_range(0, 7) == 0) begin
            add_idle(1);
            add_glitch();
            add_idle(N + 1);
         end
         good = ($urandom_range(0, 5) != 0);
         add_frame(8'($urandom_range(0, 255)), good);
         prev_bad = !good;
      end
      add_idle(LAT + 2);
      for (int i = 0; i < q_rd.size(); i++) q_rd[i] = ($urandom_range(0, 7) == 0);
      play("random");

      // Reset in the middle of a frame with the line still low.
      do_reset();
      send_frame(8'hA5, 1'b1, t0);
      wait_until(t0 + LAT);
      check_all("pre_mid_reset", 8'hA5, 1'b1, 1'b0, 1'b0);
      t0 = cyc + 1;
      for (int j = 0; j < 9; j++) tick(frame_bit(8'h5A, 1'b1, j), 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      check_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < HOLD_LOW; j++) begin
         tick(1'b0, 1'b0, 1'b0);
         check_all("held_low", 8'h00, 1'b0, 1'b0, 1'b0);
      end
      repeat (3) tick(1'b1, 1'b0, 1'b0);
      send_frame(8'h7E, 1'b1, t0);
      wait_until(t0 + LAT - 1);
      check_all("after_reset.before_commit", 8'h00, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      check_all("after_reset.commit", 8'h7E, 1'b1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
